// File: rtl/mario_video_pkg.sv
// rtl/mario_video_pkg.sv - shared palette and RGB definitions for the video mixer
//
// Purpose: palette download window, palette depth, 3-3-2 RGB field widths,
//          palette index field layout, and helpers to build an index and
//          decode the inverted PROM colour format.
// Ports:   none (package).

package mario_video_pkg;

  localparam logic [16:0] PAL_BASE  = 17'h0F000;
  localparam int          PAL_DEPTH = 256;
  localparam int          PAL_AW    = 8;

  localparam int R_W = 3;
  localparam int G_W = 3;
  localparam int B_W = 2;

  // Palette index layout: {bank, sel, col[3:0], vid[1:0]}
  localparam int IDX_BANK    = 7;
  localparam int IDX_SEL     = 6;
  localparam int IDX_COL_LSB = 2;
  localparam int IDX_VID_LSB = 0;

  typedef logic [PAL_AW-1:0] pal_idx_t;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb_t;

  function automatic pal_idx_t pal_index(input logic bank, input logic sel,
                                         input logic [3:0] col, input logic [1:0] vid);
    pal_idx_t idx;
    idx = '0;
    idx[IDX_BANK]              = bank;
    idx[IDX_SEL]               = sel;
    idx[IDX_COL_LSB +: 4]      = col;
    idx[IDX_VID_LSB +: 2]      = vid;
    return idx;
  endfunction

  // The palette bytes are stored inverted (PROM heritage); r/g/b occupy
  // d[7:5]/d[4:2]/d[1:0], which matches the packed rgb_t layout.
  function automatic rgb_t decode_prom(input logic [7:0] d);
    return rgb_t'(~d);
  endfunction

endpackage

// File: rtl/mario_pal_ram.sv
// rtl/mario_pal_ram.sv - 256x8 palette RAM, one write port, one registered read port
//
// Purpose: palette storage; a read and a write to the same entry in the same
//          cycle returns the old data (read-before-write). Contents are not reset.
// Ports:   clk          - clock
//          we/waddr/wdata - write port
//          re/raddr     - read enable and address
//          rdata        - registered read data

module mario_pal_ram
  import mario_video_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  pal_idx_t   waddr,
  input  logic [7:0] wdata,
  input  logic       re,
  input  pal_idx_t   raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [PAL_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mario_colmix.sv
// rtl/mario_colmix.sv - background/sprite priority mixer with palette lookup and 3-3-2 RGB out
//
// Purpose: resolves sprite-over-background priority, looks the colour up in a
//          downloadable palette RAM, and emits registered RGB with blanking
//          delayed to match (3 pixel enables input to output).
// Option:  MARIO_COLMIX_LAYER_MASK_EN adds I_BG_EN / I_OBJ_EN layer enables.
// Ports:   I_CLK_48M, I_RESETn (sync, active-low), I_CEN_PIX pixel enable
//          I_BG_COL/I_BG_VID, I_OBJ_COL/I_OBJ_VID, I_PALBANK - pixel inputs
//          I_HBLANK/I_VBLANK - blanking aligned with the pixel inputs
//          I_DLADDR/I_DLDATA/I_DLWR - ROM download stream (palette load)
//          O_R/O_G/O_B - RGB, O_HBLANK/O_VBLANK - delayed blanking
//          O_PAL_READY - all 256 palette bytes loaded

module mario_colmix
  import mario_video_pkg::*;
(
  input  logic        I_CLK_48M,
  input  logic        I_RESETn,
  input  logic        I_CEN_PIX,
  input  logic [3:0]  I_BG_COL,
  input  logic [1:0]  I_BG_VID,
  input  logic [3:0]  I_OBJ_COL,
  input  logic [1:0]  I_OBJ_VID,
  input  logic        I_PALBANK,
  input  logic        I_HBLANK,
  input  logic        I_VBLANK,
`ifdef MARIO_COLMIX_LAYER_MASK_EN
  input  logic        I_BG_EN,
  input  logic        I_OBJ_EN,
`endif
  input  logic [16:0] I_DLADDR,
  input  logic [7:0]  I_DLDATA,
  input  logic        I_DLWR,
  output logic [2:0]  O_R,
  output logic [2:0]  O_G,
  output logic [1:0]  O_B,
  output logic        O_HBLANK,
  output logic        O_VBLANK,
  output logic        O_PAL_READY
);

  localparam logic [16:0] PAL_LAST = PAL_BASE + 17'(PAL_DEPTH - 1);
  localparam logic [8:0]  CNT_FULL = 9'(PAL_DEPTH);

  logic bg_en;
  logic obj_en;

`ifdef MARIO_COLMIX_LAYER_MASK_EN
  assign bg_en  = I_BG_EN;
  assign obj_en = I_OBJ_EN;
`else
  assign bg_en  = 1'b1;
  assign obj_en = 1'b1;
`endif

  // S0 index: sprite wins whenever it is opaque; a masked background still
  // shows its backdrop entry (vid = 0).
  logic     sel;
  logic [1:0] bg_vid;
  pal_idx_t idx_next;

  always_comb begin
    sel      = obj_en && (I_OBJ_VID != 2'd0);
    bg_vid   = bg_en ? I_BG_VID : 2'd0;
    idx_next = pal_index(I_PALBANK, sel, sel ? I_OBJ_COL : I_BG_COL,
                         sel ? I_OBJ_VID : bg_vid);
  end

  pal_idx_t s0_idx;
  logic     s0_hb, s0_vb;
  logic     s1_hb, s1_vb;

  always_ff @(posedge I_CLK_48M) begin
    if (!I_RESETn) begin
      s0_idx <= '0;
      s0_hb  <= 1'b1;
      s0_vb  <= 1'b1;
      s1_hb  <= 1'b1;
      s1_vb  <= 1'b1;
    end else if (I_CEN_PIX) begin
      s0_idx <= idx_next;
      s0_hb  <= I_HBLANK;
      s0_vb  <= I_VBLANK;
      s1_hb  <= s0_hb;
      s1_vb  <= s0_vb;
    end
  end

  // Palette load; reset dominates a coincident write.
  logic       in_window;
  logic       pal_we;
  logic [7:0] ram_q;

  assign in_window = (I_DLADDR >= PAL_BASE) && (I_DLADDR <= PAL_LAST);
  assign pal_we    = I_RESETn && I_DLWR && in_window;

  mario_pal_ram u_pal_ram (
    .clk   (I_CLK_48M),
    .we    (pal_we),
    .waddr (I_DLADDR[PAL_AW-1:0]),
    .wdata (I_DLDATA),
    .re    (I_CEN_PIX),
    .raddr (s0_idx),
    .rdata (ram_q)
  );

  logic [8:0] load_cnt;

  always_ff @(posedge I_CLK_48M) begin
    if (!I_RESETn) begin
      load_cnt    <= '0;
      O_PAL_READY <= 1'b0;
    end else begin
      if (pal_we && (load_cnt != CNT_FULL)) begin
        load_cnt <= load_cnt + 9'd1;
      end
      O_PAL_READY <= (load_cnt == CNT_FULL);
    end
  end

  // S2: decode and blank. Output stays black until the palette is complete.
  rgb_t rgb_dec;
  rgb_t rgb_q;
  logic force_black;

  assign rgb_dec     = decode_prom(ram_q);
  assign force_black = s1_hb || s1_vb || !O_PAL_READY;

  always_ff @(posedge I_CLK_48M) begin
    if (!I_RESETn) begin
      rgb_q    <= '0;
      O_HBLANK <= 1'b1;
      O_VBLANK <= 1'b1;
    end else if (I_CEN_PIX) begin
      rgb_q    <= force_black ? '0 : rgb_dec;
      O_HBLANK <= s1_hb;
      O_VBLANK <= s1_vb;
    end
  end

  assign O_R = rgb_q.r;
  assign O_G = rgb_q.g;
  assign O_B = rgb_q.b;

endmodule

// File: doc/mario_colmix.md
Name: mario_colmix

Overview:
- Pixel-rate colour mixer directly downstream of the background tile generator and the sprite engine.
- Takes the background pixel (2-bit pattern plus 4-bit colour) and the sprite pixel, and resolves priority.
- Looks the result up in a 256x8 palette RAM and emits registered 3-3-2 RGB with aligned blanking.
- The palette RAM is loaded from the ROM download stream on the same clock.

Parameters:
- PAL_BASE, 17'h0F000, first download address of the 256-byte palette region.
- PIPE_LAT, 3, pixel-enable latency from input to RGB output. Fixed; used by the bench only.

Ports:
- I_CLK_48M  in  1  system clock.
- I_RESETn  in  1  synchronous reset, active-low.
- I_CEN_PIX  in  1  pixel clock enable, one I_CLK_48M cycle wide.
- I_BG_COL  in  4  background colour from the tile stage.
- I_BG_VID  in  2  background pattern bits.
- I_OBJ_COL  in  4  sprite colour.
- I_OBJ_VID  in  2  sprite pattern bits; 0 means transparent.
- I_PALBANK  in  1  palette bank select (CPU latch).
- I_HBLANK  in  1  horizontal blank, aligned with the pixel inputs.
- I_VBLANK  in  1  vertical blank, aligned with the pixel inputs.
- I_DLADDR  in  17  download address.
- I_DLDATA  in  8  download data.
- I_DLWR  in  1  download write strobe, one cycle per byte.
- O_R  out  3  red.
- O_G  out  3  green.
- O_B  out  2  blue.
- O_HBLANK  out  1  delayed horizontal blank.
- O_VBLANK  out  1  delayed vertical blank.
- O_PAL_READY  out  1  high once all 256 palette bytes are loaded.

Behaviour:
- Clock and reset: single clock I_CLK_48M. Reset I_RESETn is synchronous, active-low.
- Reset values:
  - O_R, O_G, O_B = 0.
  - O_HBLANK, O_VBLANK = 1.
  - O_PAL_READY = 0.
  - Load counter = 0; all pipeline registers cleared with blank = 1.
  - Palette RAM contents are not reset.
- Pipeline: all three stages advance only when I_CEN_PIX = 1; otherwise everything holds.
  - S0: register the inputs and compute the palette index.
    - sel = (I_OBJ_VID != 0).
    - Index[7:0] = {I_PALBANK, sel, sel ? I_OBJ_COL : I_BG_COL, sel ? I_OBJ_VID : I_BG_VID}.
    - When both layers are transparent, the index is the background entry with vid = 0 (backdrop).
  - S1: synchronous read of the palette RAM at the index; blank flags carried along.
  - S2: decode the inverted PROM format, d = RAM data:
    - R = ~d[7:5], G = ~d[4:2], B = ~d[1:0].
    - Force RGB to 0 if the carried HBLANK or VBLANK is set, or if O_PAL_READY = 0.
    - Register RGB and the blank outputs.
- Latency: exactly 3 I_CEN_PIX pulses from input to output, for RGB and both blank outputs.
- Palette load:
  - On any cycle with I_DLWR = 1 and PAL_BASE <= I_DLADDR <= PAL_BASE+255, write I_DLDATA to RAM[I_DLADDR[7:0]].
  - The write is independent of I_CEN_PIX.
  - Same-cycle read/write to the same entry: the read returns the old data; the new data is visible on the next read.
  - Writes outside the window are ignored.
- Load counter (9 bits):
  - Increments on each in-window write and saturates at 256.
  - O_PAL_READY = (counter == 256), registered, so it rises 1 cycle after the 256th write.
  - Rewriting entries after ready is allowed; ready stays high and the new data takes effect.
- Reset mid-download:
  - Counter clears and ready drops.
  - RAM keeps what was written.
  - A write in the same cycle as reset is ignored (reset dominates).
- Simultaneous sprite and background opaque: sprite wins. No per-tile priority bit exists.

Optional Feature:
- Macro: MARIO_COLMIX_LAYER_MASK_EN.
- When defined:
  - Extra inputs I_BG_EN and I_OBJ_EN (1 bit each, sampled in S0).
  - I_OBJ_EN = 0 forces sel = 0.
  - I_BG_EN = 0 forces the background vid to 0 (backdrop colour still shown).
- When undefined: no extra ports; both layers are always enabled.

Decomposition:
- Shared package mario_video_pkg holds:
  - PAL_BASE.
  - Palette depth 256.
  - RGB field widths 3/3/2.
  - The palette index field layout (bank, sel, col, vid bit positions).
- One sub-module: mario_pal_ram, a 256x8 RAM with one write port and one registered read port with read-before-write semantics.
- Mixing, counter and pipeline stay in mario_colmix.

Test Plan:
- Load: 256 writes with RAM[i] = i starting at PAL_BASE → O_PAL_READY = 0 after 255 writes and 1 one cycle after the 256th; writes at PAL_BASE-1 and PAL_BASE+256 leave the counter unchanged.
- Priority: PALBANK = 0, BG col = 5 vid = 2, OBJ vid = 0 → index 0x16; RAM = 0x00 → RGB = 7/7/3 after exactly 3 pixel enables. Then OBJ col = 3 vid = 1 → index 0x4D.
- Blanking: I_HBLANK pulse of 4 pixels → O_HBLANK pulse of 4 pixels delayed by 3 enables; RGB = 0 throughout, including the pixels where RAM data would give non-zero.
- Enable gating: I_CEN_PIX held low for 10 cycles mid-line → outputs frozen; resume → sequence continues with no dropped or duplicated pixel.
- Collision: a write to entry 0x16 in the same cycle as S1 reads 0x16 → old value output for that pixel, new value for the next pixel at 0x16.
- Reset: assert I_RESETn = 0 after 100 loaded bytes, then load 256 → O_PAL_READY only after the full 256 post-reset writes; RGB = 0 and blanks = 1 during reset.
